// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
// Holds the datapath width, the PC increment and the FSM state encoding.

`ifndef WIDTH
`define WIDTH 32
`endif

package fetch_ctrl_pkg;

    // Address / instruction width, tied to the global `WIDTH define.
    localparam int unsigned WORD_W = `WIDTH;

    // Byte distance between sequential instructions.
    localparam int unsigned PC_INC = 4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack channel.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : fetch address (master -> slave)
//   imem_ack   : request accepted, rdata valid this cycle (slave -> master)
//   imem_rdata : fetched instruction (slave -> master)

interface fetch_ctrl_if #(
    parameter int unsigned WIDTH = fetch_ctrl_pkg::WORD_W
) ();

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;

    // Fetch controller side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Instruction memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface : fetch_ctrl_if

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that arrived while IF/ID was
// stalled by a load-use hazard.
//   clk, rst : clock, synchronous active-low reset
//   load     : capture data_in and mark valid
//   clear    : discard the held word (redirect)
//   drain    : held word consumed by IF/ID
//   data_in  : word to capture
//   valid    : a word is held
//   data     : held word

module fetch_skid_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Clear/drain win over load; the controller never asks for both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear || drain) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end
    end

endmodule : fetch_skid_buf

// File: rtl/fetch_ctrl.sv
// PC sequencing and instruction fetch for the 5-stage MIPS pipeline.
// Arbitrates redirects (EX branch over ID jump), load-use stalls and memory
// wait states, and steers fetched words into IF/ID or the skid buffer.
//   clk, rst       : clock, synchronous active-low reset
//   pc_cur         : current PC from the PC register
//   pc_next        : next PC to the PC register
//   stall_pc       : hold the PC register
//   imem           : instruction-memory req/ack channel (master)
//   hazard_stall   : load-use stall from ID
//   branch_taken   : EX redirect, branch_target its destination
//   jump           : ID redirect, jump_target its destination
//   ifid_load      : load IF/ID with inst_out
//   flush_ifid     : clear IF/ID to a bubble
//   inst_out       : instruction into IF/ID
// Outputs are combinational from state and inputs.

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH    = WORD_W,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_next,
    output logic             stall_pc,
    fetch_ctrl_if.master     imem,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic             ifid_load,
    output logic             flush_ifid,
    output logic [WIDTH-1:0] inst_out
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;

    logic             redir;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;
    logic             req_active;

    logic             buf_load;
    logic             buf_clear;
    logic             buf_drain;
    logic             buf_valid;
    logic [WIDTH-1:0] buf_data;

    logic             pend_load;
    logic [WIDTH-1:0] pend_target;

    // Redirect mux: EX branch outranks ID jump.
    assign redir  = branch_taken | jump;
    assign target = branch_taken ? branch_target : jump_target;
    assign pc_inc = pc_cur + WIDTH'(PC_INC);

    // A request is outstanding in BUSY/DRAIN; FETCH only starts one when
    // the skid buffer is empty and ID is not stalled.
    assign req_active = (state == ST_BUSY) || (state == ST_DRAIN) ||
                        ((state == ST_FETCH) && !buf_valid && !hazard_stall);

    // Address follows the PC; the PC is held while a request waits.
    assign imem.imem_req  = req_active;
    assign imem.imem_addr = pc_cur;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect target remembered while an abandoned request drains.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_target <= '0;
        end else if (pend_load) begin
            pend_target <= target;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_BUSY: begin
                if (req_active) begin
                    if (imem.imem_ack) begin
                        state_nxt = ST_FETCH;
                    end else if (redir) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_BUSY;
                    end
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Output and datapath-control logic.
    always_comb begin
        pc_next    = pc_inc;
        stall_pc   = 1'b1;
        ifid_load  = 1'b0;
        flush_ifid = 1'b0;
        inst_out   = '0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        buf_drain  = 1'b0;
        pend_load  = 1'b0;

        case (state)
            ST_BOOT: begin
                pc_next = RESET_PC;
            end
            ST_FETCH, ST_BUSY: begin
                if (req_active) begin
                    if (imem.imem_ack) begin
                        stall_pc = 1'b0;
                        if (redir) begin
                            // Word belongs to the wrong path: drop it.
                            pc_next    = target;
                            flush_ifid = 1'b1;
                            buf_clear  = 1'b1;
                        end else if (!hazard_stall) begin
                            inst_out  = imem.imem_rdata;
                            ifid_load = 1'b1;
                        end else begin
                            // IF/ID is frozen; park the word.
                            buf_load = 1'b1;
                        end
                    end else if (redir) begin
                        // Request cannot be withdrawn; drain it first.
                        pend_load  = 1'b1;
                        flush_ifid = 1'b1;
                    end
                end else if (redir) begin
                    pc_next    = target;
                    stall_pc   = 1'b0;
                    flush_ifid = 1'b1;
                    buf_clear  = 1'b1;
                end else if (buf_valid && !hazard_stall) begin
                    // Replay the parked word; PC already advanced past it.
                    inst_out  = buf_data;
                    ifid_load = 1'b1;
                    buf_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (imem.imem_ack) begin
                    stall_pc = 1'b0;
                    if (redir) begin
                        pc_next    = target;
                        flush_ifid = 1'b1;
                    end else begin
                        pc_next = pend_target;
                    end
                end else if (redir) begin
                    pend_load  = 1'b1;
                    flush_ifid = 1'b1;
                end
            end
            default: begin
                pc_next = RESET_PC;
            end
        endcase
    end

    fetch_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .clear  (buf_clear),
        .drain  (buf_drain),
        .data_in(imem.imem_rdata),
        .valid  (buf_valid),
        .data   (buf_data)
    );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        stall_pc;
    logic        hazard_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        ifid_load;
    logic        flush_ifid;
    logic [31:0] inst_out;

    int n_checks;
    int n_fail;

    fetch_ctrl_if #(.WIDTH(32)) imem_bus ();

    fetch_ctrl #(
        .WIDTH   (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_cur       (pc_cur),
        .pc_next      (pc_next),
        .stall_pc     (stall_pc),
        .imem         (imem_bus),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .ifid_load    (ifid_load),
        .flush_ifid   (flush_ifid),
        .inst_out     (inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset imem_req: got %b expected 0", imem_bus.imem_req); end
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset pc_next: got %h expected 00000000", pc_next); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL reset stall_pc: got %b expected 1", stall_pc); end
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL reset ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL reset flush_ifid: got %b expected 0", flush_ifid); end
        tick();
        rst = 1'b1;
        sample();
        // Still BOOT for the first cycle after release.
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot imem_req: got %b expected 0", imem_bus.imem_req); end
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL boot pc_next: got %h expected 00000000", pc_next); end
        tick();
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 3; i++) begin
            pc_cur                = 32'(4 * i);
            imem_bus.imem_ack     = 1'b1;
            imem_bus.imem_rdata   = 32'hA000_0000 + 32'(i);
            sample();
            n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL free_run[%0d] imem_req: got %b expected 1", i, imem_bus.imem_req); end
            n_checks++; if (imem_bus.imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL free_run[%0d] imem_addr: got %h expected %h", i, imem_bus.imem_addr, 32'(4 * i)); end
            n_checks++; if (pc_next !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL free_run[%0d] pc_next: got %h expected %h", i, pc_next, 32'(4 * (i + 1))); end
            n_checks++; if (ifid_load !== 1'b1) begin n_fail++; $display("FAIL free_run[%0d] ifid_load: got %b expected 1", i, ifid_load); end
            n_checks++; if (inst_out !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL free_run[%0d] inst_out: got %h expected %h", i, inst_out, 32'hA000_0000 + 32'(i)); end
            n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL free_run[%0d] stall_pc: got %b expected 0", i, stall_pc); end
            tick();
        end
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_mem_wait();
        pc_cur            = 32'h10;
        imem_bus.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL mem_wait[%0d] imem_req: got %b expected 1", i, imem_bus.imem_req); end
            n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL mem_wait[%0d] stall_pc: got %b expected 1", i, stall_pc); end
            n_checks++; if (imem_bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL mem_wait[%0d] imem_addr: got %h expected 00000010", i, imem_bus.imem_addr); end
            n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL mem_wait[%0d] ifid_load: got %b expected 0", i, ifid_load); end
            tick();
        end
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        sample();
        n_checks++; if (pc_next !== 32'h14) begin n_fail++; $display("FAIL mem_wait ack pc_next: got %h expected 00000014", pc_next); end
        n_checks++; if (ifid_load !== 1'b1) begin n_fail++; $display("FAIL mem_wait ack ifid_load: got %b expected 1", ifid_load); end
        n_checks++; if (inst_out !== 32'h1234_5678) begin n_fail++; $display("FAIL mem_wait ack inst_out: got %h expected 12345678", inst_out); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_branch();
        pc_cur              = 32'h20;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h5555_5555;
        branch_taken        = 1'b1;
        branch_target       = 32'h100;
        sample();
        n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL branch flush_ifid: got %b expected 1", flush_ifid); end
        n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL branch pc_next: got %h expected 00000100", pc_next); end
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL branch ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL branch stall_pc: got %b expected 0", stall_pc); end
        tick();
        jump        = 1'b1;
        jump_target = 32'h200;
        sample();
        n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL branch_vs_jump pc_next: got %h expected 00000100", pc_next); end
        n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL branch_vs_jump flush_ifid: got %b expected 1", flush_ifid); end
        tick();
        branch_taken      = 1'b0;
        jump              = 1'b0;
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_drain();
        pc_cur            = 32'h30;
        imem_bus.imem_ack = 1'b0;
        branch_taken      = 1'b1;
        branch_target     = 32'h80;
        sample();
        n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL drain enter flush_ifid: got %b expected 1", flush_ifid); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL drain enter stall_pc: got %b expected 1", stall_pc); end
        tick();
        branch_taken = 1'b0;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drain wait imem_req: got %b expected 1", imem_bus.imem_req); end
        n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL drain wait flush_ifid: got %b expected 0", flush_ifid); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL drain wait stall_pc: got %b expected 1", stall_pc); end
        tick();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hBAD0_0BAD;
        sample();
        n_checks++; if (pc_next !== 32'h80) begin n_fail++; $display("FAIL drain ack pc_next: got %h expected 00000080", pc_next); end
        n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL drain ack stall_pc: got %b expected 0", stall_pc); end
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL drain ack ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL drain ack flush_ifid: got %b expected 0", flush_ifid); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_drain_retarget();
        pc_cur            = 32'h60;
        imem_bus.imem_ack = 1'b0;
        jump              = 1'b1;
        jump_target       = 32'h90;
        tick();
        jump          = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'hA0;
        sample();
        n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL retarget flush_ifid: got %b expected 1", flush_ifid); end
        tick();
        branch_taken        = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h0;
        sample();
        n_checks++; if (pc_next !== 32'hA0) begin n_fail++; $display("FAIL retarget pc_next: got %h expected 000000a0", pc_next); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_hazard_skid();
        pc_cur            = 32'h40;
        imem_bus.imem_ack = 1'b0;
        tick();
        hazard_stall        = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        sample();
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL skid ack ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL skid ack stall_pc: got %b expected 0", stall_pc); end
        n_checks++; if (pc_next !== 32'h44) begin n_fail++; $display("FAIL skid ack pc_next: got %h expected 00000044", pc_next); end
        tick();
        pc_cur              = 32'h44;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL skid hold imem_req: got %b expected 0", imem_bus.imem_req); end
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL skid hold ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL skid hold stall_pc: got %b expected 1", stall_pc); end
        tick();
        hazard_stall = 1'b0;
        sample();
        n_checks++; if (inst_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL skid release inst_out: got %h expected deadbeef", inst_out); end
        n_checks++; if (ifid_load !== 1'b1) begin n_fail++; $display("FAIL skid release ifid_load: got %b expected 1", ifid_load); end
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL skid release imem_req: got %b expected 0", imem_bus.imem_req); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL skid release stall_pc: got %b expected 1", stall_pc); end
        tick();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1111_1111;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL skid after imem_req: got %b expected 1", imem_bus.imem_req); end
        n_checks++; if (inst_out !== 32'h1111_1111) begin n_fail++; $display("FAIL skid after inst_out: got %h expected 11111111", inst_out); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_buf_redirect();
        pc_cur            = 32'h70;
        imem_bus.imem_ack = 1'b0;
        tick();
        hazard_stall        = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hCAFE_F00D;
        tick();
        pc_cur            = 32'h74;
        hazard_stall      = 1'b0;
        imem_bus.imem_ack = 1'b0;
        branch_taken      = 1'b1;
        branch_target     = 32'h300;
        sample();
        n_checks++; if (pc_next !== 32'h300) begin n_fail++; $display("FAIL bufredir pc_next: got %h expected 00000300", pc_next); end
        n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL bufredir flush_ifid: got %b expected 1", flush_ifid); end
        n_checks++; if (ifid_load !== 1'b0) begin n_fail++; $display("FAIL bufredir ifid_load: got %b expected 0", ifid_load); end
        n_checks++; if (stall_pc !== 1'b0) begin n_fail++; $display("FAIL bufredir stall_pc: got %b expected 0", stall_pc); end
        tick();
        branch_taken        = 1'b0;
        pc_cur              = 32'h300;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h2222_2222;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL bufredir after imem_req: got %b expected 1", imem_bus.imem_req); end
        n_checks++; if (inst_out !== 32'h2222_2222) begin n_fail++; $display("FAIL bufredir after inst_out: got %h expected 22222222", inst_out); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        pc_cur              = 32'hFFFF_FFFC;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h3333_3333;
        sample();
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap pc_next: got %h expected 00000000", pc_next); end
        n_checks++; if (ifid_load !== 1'b1) begin n_fail++; $display("FAIL wrap ifid_load: got %b expected 1", ifid_load); end
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset_busy();
        pc_cur            = 32'h50;
        imem_bus.imem_ack = 1'b0;
        tick();
        rst = 1'b0;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy pre imem_req: got %b expected 1", imem_bus.imem_req); end
        tick();
        rst = 1'b1;
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_busy boot imem_req: got %b expected 0", imem_bus.imem_req); end
        n_checks++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL rst_busy boot pc_next: got %h expected 00000000", pc_next); end
        n_checks++; if (stall_pc !== 1'b1) begin n_fail++; $display("FAIL rst_busy boot stall_pc: got %b expected 1", stall_pc); end
        tick();
        sample();
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy fetch imem_req: got %b expected 1", imem_bus.imem_req); end
        tick();
    endtask

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        rst                 = 1'b0;
        pc_cur              = 32'h0;
        hazard_stall        = 1'b0;
        branch_taken        = 1'b0;
        branch_target       = 32'h0;
        jump                = 1'b0;
        jump_target         = 32'h0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        test_reset();
        test_free_run();
        test_mem_wait();
        test_branch();
        test_drain();
        test_drain_retarget();
        test_hazard_skid();
        test_buf_redirect();
        test_wrap();
        test_reset_busy();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and instruction-memory fetch for the 5-stage MIPS pipeline.
- Drives the PC register's next value and stall, issues imem requests with a req/ack handshake, and loads or flushes the IF/ID register.
- Arbitrates between branch/jump redirects, load-use hazard stalls and memory wait states.
- Holds a one-entry skid buffer so a word returned during a hazard stall is not lost.

Parameters:
- WIDTH, 32, address and instruction width (matches the `WIDTH define).
- RESET_PC, 0, must equal the PC register reset value. Used only for the pc_next reset value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- pc_cur  in  WIDTH  current PC from the PC register
- pc_next  out  WIDTH  next PC, to the PC register's pc_in
- stall_pc  out  1  hold the PC register
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address; equals pc_cur
- imem_ack  in  1  request accepted; imem_rdata is valid in the same cycle
- imem_rdata  in  WIDTH  fetched instruction
- hazard_stall  in  1  load-use stall from ID; IF/ID must hold
- branch_taken  in  1  redirect from EX
- branch_target  in  WIDTH  branch target
- jump  in  1  redirect from ID
- jump_target  in  WIDTH  jump target
- ifid_load  out  1  load enable for the IF/ID register
- flush_ifid  out  1  clear IF/ID to a bubble
- inst_out  out  WIDTH  instruction into IF/ID, valid when ifid_load=1

Behaviour:
- State registers: state (BOOT, FETCH, BUSY, DRAIN), buf_valid, buf_data, pend_target.
- Outputs are combinational from state and inputs. The defaults below apply unless a rule overrides them.
- Defaults: pc_next=pc_cur+4 (mod 2^WIDTH, wraps), stall_pc=1, ifid_load=0, flush_ifid=0, inst_out=0.
- Redirect: redir = branch_taken | jump. Target = branch_target if branch_taken, else jump_target (EX has priority over ID).
- Priority: redirect > hazard_stall > memory wait.
- Reset (rst=0 at a clock edge): state=BOOT, buf_valid=0, buf_data=0, pend_target=0. A reset mid-request abandons the outstanding request.
- BOOT outputs: imem_req=0, stall_pc=1, pc_next=RESET_PC, ifid_load=0, flush_ifid=0. BOOT always moves to FETCH after one cycle.
- Request condition: imem_req=1 in BUSY and DRAIN. In FETCH, imem_req=1 only when !buf_valid && !hazard_stall; otherwise imem_req=0 and stall_pc=1.
- FETCH/BUSY with imem_req=1:
  - ack & redir: pc_next=target, stall_pc=0, flush_ifid=1, word discarded, buf_valid cleared, next state FETCH.
  - ack & !redir & !hazard_stall: inst_out=imem_rdata, ifid_load=1, stall_pc=0, next state FETCH.
  - ack & !redir & hazard_stall: buf_data<=imem_rdata, buf_valid<=1, stall_pc=0, ifid_load=0, next state FETCH.
  - !ack & redir: pend_target<=target, flush_ifid=1, stall_pc=1, next state DRAIN.
  - !ack & !redir: stall_pc=1, next state BUSY. imem_addr stays stable because the PC is held.
- FETCH with buf_valid=1:
  - redir: buf_valid<=0, pc_next=target, stall_pc=0, flush_ifid=1.
  - !redir & !hazard_stall: inst_out=buf_data, ifid_load=1, buf_valid<=0, stall_pc=1, no request this cycle.
  - hazard_stall: hold everything.
- DRAIN (imem_req=1, address held):
  - redir without ack: pend_target<=new target; flush_ifid=1.
  - ack: discard the word, pc_next = live target if redir else pend_target, stall_pc=0, flush_ifid=redir, next state FETCH.
- Invariants:
  - ifid_load and flush_ifid are never both 1.
  - ifid_load=0 whenever hazard_stall=1.
  - imem_req drops only in the cycle after an ack.

Decomposition:
- Shared package/defines: the `WIDTH define, the state encoding (2-bit BOOT=0, FETCH=1, BUSY=2, DRAIN=3), and the PC increment constant 4.
- One natural sub-module: fetch_skid_buf, the one-entry buffer (load, clear, drain, valid, data).
- The FSM and redirect mux stay in fetch_ctrl.

Test Plan:
- Reset then free run with ack=1 every cycle: BOOT for 1 cycle, then pc_next = 0x4, 0x8, 0xC on successive cycles; ifid_load=1 each fetch cycle, inst_out=imem_rdata.
- pc_cur=0x10, ack held low 3 cycles: imem_req=1 and stall_pc=1 for 3 cycles with imem_addr=0x10; on ack, pc_next=0x14 and ifid_load=1.
- branch_taken=1, target 0x100, together with ack at pc 0x20: flush_ifid=1 and pc_next=0x100. Repeat with jump=1 (target 0x200) asserted at the same time: 0x100 still wins.
- Redirect to 0x80 while the request is waiting (ack=0): DRAIN entered, flush_ifid=1; ack 2 cycles later discards the word and gives pc_next=0x80.
- hazard_stall=1 in the ack cycle, imem_rdata=0xDEADBEEF: buf_valid=1 and ifid_load=0. Release hazard_stall: inst_out=0xDEADBEEF, ifid_load=1, no imem_req that cycle.
- Boundary cases:
  - pc_cur=0xFFFFFFFC with ack gives pc_next=0x0.
  - Asserting rst=0 during BUSY returns to BOOT next cycle with imem_req=0 and pc_next=RESET_PC.
